div8_seq: RTL and testbench

Sequential 8-bit unsigned restoring divider for the 8-bit ALU datapath. It computes quotient and remainder over 8 iteration cycles. Each iteration's trial subtraction uses the team's 8-bit lookahead adder `mlcla` in the subtract direction (divisor inverted, `c0`=1). It sits beside the combinational adder as the ALU's divide unit and exposes a start/busy/done handshake to the ALU control.

---
 rtl/div8_seq.sv | 165 ++++++++++++++++
 tb/tb_div8_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div8_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : div8_seq (with helper adder mlcla)                        |
// | Function : 8-bit unsigned restoring divider, one quotient bit/cycle  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

module mlcla (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c0,
  output logic [7:0] z,
  output logic       c8
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [1:0] w_gg;
  logic [1:0] w_gp;
  logic [1:0] w_cin;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Two 4-bit lookahead groups; group carries are resolved one level up.
  generate
    for (genvar k = 0; k < 2; k++) begin : g_grp
      logic [3:0] w_lg;
      logic [3:0] w_lp;
      logic [3:0] w_c;
      assign w_lg   = w_g[4*k +: 4];
      assign w_lp   = w_p[4*k +: 4];
      assign w_c[0] = w_cin[k];
      assign w_c[1] = w_lg[0] | (w_lp[0] & w_c[0]);
      assign w_c[2] = w_lg[1] | (w_lp[1] & w_lg[0]) | (w_lp[1] & w_lp[0] & w_c[0]);
      assign w_c[3] = w_lg[2] | (w_lp[2] & w_lg[1]) | (w_lp[2] & w_lp[1] & w_lg[0])
                    | (w_lp[2] & w_lp[1] & w_lp[0] & w_c[0]);
      assign w_gg[k] = w_lg[3] | (w_lp[3] & w_lg[2]) | (w_lp[3] & w_lp[2] & w_lg[1])
                     | (w_lp[3] & w_lp[2] & w_lp[1] & w_lg[0]);
      assign w_gp[k] = &w_lp;
      assign z[4*k +: 4] = w_lp ^ w_c;
    end
  endgenerate

  assign w_cin[0] = c0;
  assign w_cin[1] = w_gg[0] | (w_gp[0] & c0);
  assign c8       = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c0);
endmodule

module div8_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic       dbz
);
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_cnt;
  logic [7:0] r_dvd;
  logic [7:0] r_div;
  logic [7:0] r_rem;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic       r_done;
  logic       r_dbz;
  logic       r_zpend;

  logic [8:0] w_s;
  logic [7:0] w_z;
  logic       w_c8;
  logic       w_ok;
  logic [7:0] w_rem_nx;
  logic [7:0] w_dvd_nx;
  logic       w_accept;
  logic       w_last;

  assign w_s = {r_rem, r_dvd[7]};

  mlcla u_sub (
    .x  (w_s[7:0]),
    .y  (~r_div),
    .c0 (1'b1),
    .z  (w_z),
    .c8 (w_c8)
  );

  // s[8] set means the shifted remainder already exceeds any 8-bit divisor.
  assign w_ok     = w_s[8] | w_c8;
  assign w_rem_nx = w_ok ? w_z : w_s[7:0];
  assign w_dvd_nx = {r_dvd[6:0], w_ok};
  assign w_last   = (r_cnt == 3'd7);
  // The divide-by-zero result is still pending for one cycle; new requests wait.
  assign w_accept = (r_state == S_IDLE) && start && !r_zpend;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (y != 8'd0)) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 3'd0;
      r_dvd   <= 8'd0;
      r_div   <= 8'd0;
      r_rem   <= 8'd0;
      r_q     <= 8'd0;
      r_r     <= 8'd0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_zpend <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_zpend <= 1'b0;
      if (r_state == S_RUN) begin
        r_dvd <= w_dvd_nx;
        r_rem <= w_rem_nx;
        r_cnt <= r_cnt + 3'd1;
        if (w_last) begin
          r_q    <= w_dvd_nx;
          r_r    <= w_rem_nx;
          r_dbz  <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (r_zpend) begin
        r_q    <= 8'hFF;
        r_r    <= r_dvd;
        r_dbz  <= 1'b1;
        r_done <= 1'b1;
      end else if (w_accept) begin
        r_dvd <= x;
        r_div <= y;
        r_rem <= 8'd0;
        r_cnt <= 3'd0;
        if (y == 8'd0) r_zpend <= 1'b1;
      end
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign dbz  = r_dbz;
endmodule

`default_nettype wire

// File: tb/tb_div8_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_div8_seq                                               |
// | Function : scoreboard bench for div8_seq: directed vectors + sweep   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+

module tb_div8_seq;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       dbz;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic r_prev_done = 1'b0;

  div8_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (busy && done) chk("busy_and_done", 1, 0);
    if (done && r_prev_done) chk("done_single_pulse", 1, 0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", int'(q), int'(e.q));
        chk("r", int'(r), int'(e.r));
        chk("dbz", int'(dbz), int'(e.dbz));
      end
    end
    r_prev_done = done;
  end

  task automatic push(input logic [7:0] eq, input logic [7:0] er, input logic ed);
    exp_t e;
    e.q = eq; e.r = er; e.dbz = ed;
    sb.push_back(e);
  endtask

  // Presents start for one cycle; returns at the negedge after the sampling edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit expect_it,
                       input logic [7:0] eq, input logic [7:0] er, input logic ed);
    @(negedge clk);
    start = 1'b1; x = a; y = b;
    if (expect_it) push(eq, er, ed);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic ed);
    issue(a, b, 1'b1, eq, er, ed);
    wait_done();
  endtask

  task automatic run_model(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) run(a, b, 8'hFF, a, 1'b1);
    else           run(a, b, a / b, a % b, 1'b0);
  endtask

  initial begin
    logic [7:0] xs [4];
    rst = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(dbz), 0);
    rst = 1'b0;

    // 200/7 with cycle-exact busy/done timing
    issue(8'd200, 8'd7, 1'b1, 8'd28, 8'd4, 1'b0);
    chk("busy_T0", int'(busy), 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("busy_run", int'(busy), 1);
    end
    @(negedge clk);
    chk("done_T8", int'(done), 1);
    chk("busy_T8", int'(busy), 0);
    @(negedge clk);
    chk("done_T9", int'(done), 0);

    run(8'd255, 8'd129, 8'd1,   8'd126, 1'b0);
    run(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
    run(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
    run(8'd5,   8'd9,   8'd0,   8'd5,   1'b0);
    run(8'd0,   8'd3,   8'd0,   8'd0,   1'b0);

    // divide by zero: one-cycle latency, busy never rises
    issue(8'h3C, 8'd0, 1'b1, 8'hFF, 8'h3C, 1'b1);
    chk("dbz_busy_T0", int'(busy), 0);
    chk("dbz_done_T0", int'(done), 0);
    @(negedge clk);
    chk("dbz_done_T1", int'(done), 1);
    chk("dbz_busy_T1", int'(busy), 0);
    run(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

    // reset mid-run aborts with no done
    issue(8'd100, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0);
    for (int i = 5; i <= 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end

    // second start while busy is ignored
    issue(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; x = 8'd50; y = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // restart in the done cycle
    start = 1'b1; x = 8'd50; y = 8'd5;
    push(8'd10, 8'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_q_hold", int'(q), 14);
    chk("b2b_r_hold", int'(r), 2);
    wait_done();

    // sweep every divisor for a few corner dividends
    xs[0] = 8'd0; xs[1] = 8'd127; xs[2] = 8'd128; xs[3] = 8'd255;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 256; b++)
        run_model(xs[i], 8'(b));
    for (int i = 0; i < 100; i++)
      run_model(8'($urandom_range(255)), 8'($urandom_range(255)));

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
